// File: rtl/np_pattern_seq.sv
// rtl/np_pattern_seq.sv - timed colour pattern sequencer feeding a single-pixel driver
// Generates off/solid/blink/alternate colours and pushes each change as a LOAD+SEND frame.
module np_pattern_seq #(
  parameter int GUARD_CYCLES = 8400,
  parameter int TICK_CYCLES  = 100000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        np_write_en,
  output logic        np_en,
  output logic [7:0]  np_addr,
  output logic [31:0] np_wdata,
  output logic        busy,
  output logic        phase
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t        state, state_nx;
  logic [23:0]   color_a, color_b, last_sent, target;
  logic [1:0]    ctrl;
  logic [15:0]   half_period, half_cnt, hp_eff;
  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] wait_cnt;
  logic          refresh_pending;
  logic          wr, wr_ctrl, tick_wrap, half_done;
  logic          we_nx, load_go;
  logic [31:0]   wdata_nx;
  logic          unused_wdata;

  assign wr           = cfg_we & cfg_sel;
  assign wr_ctrl      = wr && (cfg_addr == 8'h08);
  assign unused_wdata = ^cfg_wdata[31:24];
  assign np_addr      = 8'h00;

  assign hp_eff    = (half_period == 16'd0) ? 16'd1 : half_period;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign half_done = ({1'b0, half_cnt} + 17'd1) >= {1'b0, hp_eff};

  always_comb begin
    target = 24'h0;
    case (ctrl)
      2'd0: target = 24'h0;
      2'd1: target = color_a;
      2'd2: target = phase ? color_a : 24'h0;
      default: target = phase ? color_a : color_b;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      color_a     <= 24'h0;
      color_b     <= 24'h0;
      ctrl        <= 2'd0;
      half_period <= 16'd0;
    end else if (wr) begin
      case (cfg_addr)
        8'h00: color_a     <= cfg_wdata[23:0];
        8'h04: color_b     <= cfg_wdata[23:0];
        8'h08: ctrl        <= cfg_wdata[1:0];
        8'h0C: half_period <= cfg_wdata[15:0];
        default: ;
      endcase
    end
  end

  // A CTRL write restarts the pattern on colour A and outranks a coincident tick or toggle.
  always_ff @(posedge pclk) begin
    if (reset || wr_ctrl) begin
      tick_cnt <= '0;
      half_cnt <= 16'd0;
      phase    <= 1'b1;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      if (half_done) begin
        half_cnt <= 16'd0;
        phase    <= ~phase;
      end else begin
        half_cnt <= half_cnt + 16'd1;
      end
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    we_nx    = 1'b0;
    wdata_nx = 32'h0;
    load_go  = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_pending || (target != last_sent)) begin
          state_nx = LOAD;
          we_nx    = 1'b1;
          wdata_nx = {7'b0, 1'b1, target};
          load_go  = 1'b1;
        end
      end
      LOAD: begin
        state_nx = SEND;
        we_nx    = 1'b1;
        wdata_nx = 32'h0200_0000;
      end
      SEND: state_nx = WAIT;
      default: if (wait_cnt == WAIT_LAST) state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      last_sent       <= 24'h0;
      refresh_pending <= 1'b1;
      np_write_en     <= 1'b0;
      np_en           <= 1'b0;
      np_wdata        <= 32'h0;
      busy            <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= (state == WAIT) ? wait_cnt + WW'(1) : '0;
      np_write_en <= we_nx;
      np_en       <= we_nx;
      np_wdata    <= wdata_nx;
      busy        <= (state_nx != IDLE);
      if (load_go) last_sent <= target;
      if (wr) refresh_pending <= 1'b1;
      else if (load_go) refresh_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_np_pattern_seq.sv
// tb/tb_np_pattern_seq.sv - directed self-checking bench for np_pattern_seq
// Small GUARD/TICK values keep every frame and phase toggle hand-predictable.
module tb_np_pattern_seq;
  localparam int G = 6;
  localparam int T = 4;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [7:0]  cfg_addr = 8'h0;
  logic [31:0] cfg_wdata = 32'h0;
  logic        np_write_en, np_en, busy, phase;
  logic [7:0]  np_addr;
  logic [31:0] np_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int abs_cyc = 0;
  int last_send = -1000;
  int viol = 0;
  logic prev_load = 1'b0;
  logic prev_phase = 1'b1;
  logic [31:0] loads[$];
  int en_cyc[$];
  int tog[$];

  np_pattern_seq #(.GUARD_CYCLES(G), .TICK_CYCLES(T)) dut (
    .pclk(pclk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .np_write_en(np_write_en),
    .np_en(np_en), .np_addr(np_addr), .np_wdata(np_wdata), .busy(busy), .phase(phase)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    abs_cyc++;
    if (reset) begin
      last_send = -1000;
      prev_load = 1'b0;
    end
    if (np_en !== np_write_en || np_addr !== 8'h00 || (!np_write_en && np_wdata !== 32'h0)) viol++;
    if (prev_load && !(np_write_en && np_wdata == 32'h0200_0000)) viol++;
    prev_load = np_write_en && np_wdata[24];
    if (np_write_en) begin
      en_cyc.push_back(cyc);
      if (np_wdata == 32'h0200_0000) last_send = abs_cyc;
      if (np_wdata[24]) begin
        loads.push_back(np_wdata);
        if (abs_cyc - last_send < G + 2) viol++;
      end
    end
    if (phase !== prev_phase) tog.push_back(cyc);
    prev_phase = phase;
  endtask

  task automatic clear_mon();
    loads.delete();
    en_cyc.delete();
    tog.delete();
    cyc = 0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = 32'h0;
  endtask

  task automatic test_reset();
    int bc;
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (np_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", np_write_en); end
    n_checks++; if (np_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", np_en); end
    n_checks++; if (np_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", np_wdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL rst_phase: got %b want 1", phase); end
    reset = 1'b0;
    clear_mon();
    step();
    n_checks++; if (np_write_en !== 1'b1 || np_wdata !== 32'h0100_0000) begin n_fail++; $display("FAIL boot_load: got %b/%h want 1/01000000", np_write_en, np_wdata); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL boot_busy: got %b want 1", busy); end
    step();
    n_checks++; if (np_write_en !== 1'b1 || np_wdata !== 32'h0200_0000) begin n_fail++; $display("FAIL boot_send: got %b/%h want 1/02000000", np_write_en, np_wdata); end
    bc = 2;
    for (int i = 0; i < 100 && busy; i++) begin
      step();
      if (busy) bc++;
    end
    n_checks++; if (bc !== G + 2) begin n_fail++; $display("FAIL boot_busy_len: got %0d want %0d", bc, G + 2); end
    clear_mon();
    repeat (20) step();
    n_checks++; if (en_cyc.size() !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d writes want 0", en_cyc.size()); end
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'h00; cfg_wdata = 32'h00AB_CDEF;
    step();
    cfg_we = 1'b0; cfg_wdata = 32'h0;
    repeat (20) step();
    n_checks++; if (en_cyc.size() !== 0) begin n_fail++; $display("FAIL sel_gate: got %0d writes want 0", en_cyc.size()); end
  endtask

  task automatic test_solid();
    clear_mon();
    cfg_write(8'h00, 32'h0000_FF00);
    cfg_write(8'h08, 32'h1);
    repeat (40) step();
    n_checks++; if (loads.size() !== 2) begin n_fail++; $display("FAIL solid_frames: got %0d want 2", loads.size()); end
    else begin
      n_checks++; if (loads[0] !== 32'h0100_0000) begin n_fail++; $display("FAIL solid_first: got %h want 01000000", loads[0]); end
      n_checks++; if (loads[1] !== 32'h0100_FF00) begin n_fail++; $display("FAIL solid_word: got %h want 0100ff00", loads[1]); end
    end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL solid_proto: got %0d violations want 0", viol); end
  endtask

  task automatic test_blink();
    int bad;
    logic [31:0] exp_w;
    cfg_write(8'h0C, 32'h2);
    cfg_write(8'h00, 32'h0000_00FF);
    repeat (30) step();
    cfg_write(8'h08, 32'h2);
    clear_mon();
    repeat (100) step();
    bad = 0;
    for (int i = 0; i < loads.size(); i++) begin
      exp_w = (i % 2 == 0) ? 32'h0100_00FF : 32'h0100_0000;
      if (loads[i] !== exp_w) bad++;
    end
    n_checks++; if (loads.size() < 8) begin n_fail++; $display("FAIL blink_count: got %0d want >=8", loads.size()); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL blink_alt: got %0d bad words want 0", bad); end
    bad = 0;
    for (int i = 0; i < tog.size(); i++) if (tog[i] !== 8 * (i + 1)) bad++;
    n_checks++; if (tog.size() < 10 || bad !== 0) begin n_fail++; $display("FAIL blink_phase: got %0d toggles %0d off-grid want >=10/0", tog.size(), bad); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL blink_proto: got %0d violations want 0", viol); end
  endtask

  task automatic test_wait_write();
    int exp_en[6] = '{1, 2, 10, 11, 41, 42};
    logic [31:0] exp_l[3] = '{32'h0111_1111, 32'h0111_1111, 32'h0133_3333};
    int bad;
    cfg_write(8'h08, 32'h0);
    repeat (40) step();
    cfg_write(8'h0C, 32'd10);
    cfg_write(8'h00, 32'h0011_1111);
    cfg_write(8'h04, 32'h0022_2222);
    repeat (40) step();
    cfg_write(8'h08, 32'h3);
    clear_mon();
    repeat (3) step();
    cfg_write(8'h04, 32'h0033_3333);
    repeat (46) step();
    bad = 0;
    if (en_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) if (en_cyc[i] !== exp_en[i]) bad++;
    end else bad = 99;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wait_timing: got %0d writes %0d misplaced want 6/0", en_cyc.size(), bad); end
    bad = 0;
    if (loads.size() == 3) begin
      for (int i = 0; i < 3; i++) if (loads[i] !== exp_l[i]) bad++;
    end else bad = 99;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wait_words: got %0d frames %0d wrong want 3/0", loads.size(), bad); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL wait_proto: got %0d violations want 0", viol); end
  endtask

  task automatic test_ctrl_toggle();
    cfg_write(8'h0C, 32'h2);
    cfg_write(8'h08, 32'h2);
    clear_mon();
    repeat (7) step();
    cfg_write(8'h08, 32'h2);
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL ctrl_wins: got %b want 1", phase); end
    repeat (7) step();
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL ctrl_hold: got %b want 1", phase); end
    step();
    n_checks++; if (phase !== 1'b0) begin n_fail++; $display("FAIL ctrl_next_tog: got %b want 0", phase); end
    repeat (2) step();
    cfg_write(8'h08, 32'h2);
    repeat (7) step();
    n_checks++; if (phase !== 1'b1) begin n_fail++; $display("FAIL ctrl_clear_cnt: got %b want 1", phase); end
    step();
    n_checks++; if (phase !== 1'b0) begin n_fail++; $display("FAIL ctrl_clear_tog: got %b want 0", phase); end
  endtask

  task automatic test_reset_in_send();
    cfg_write(8'h08, 32'h0);
    repeat (40) step();
    cfg_write(8'h00, 32'h0012_3456);
    repeat (30) step();
    cfg_write(8'h08, 32'h1);
    clear_mon();
    step();
    n_checks++; if (np_write_en !== 1'b1 || np_wdata !== 32'h0112_3456) begin n_fail++; $display("FAIL rs_load: got %b/%h want 1/01123456", np_write_en, np_wdata); end
    step();
    n_checks++; if (np_wdata !== 32'h0200_0000) begin n_fail++; $display("FAIL rs_send: got %h want 02000000", np_wdata); end
    reset = 1'b1;
    step();
    n_checks++; if (np_write_en !== 1'b0 || busy !== 1'b0 || np_wdata !== 32'h0) begin n_fail++; $display("FAIL rs_abort: got we=%b busy=%b wd=%h want 0/0/0", np_write_en, busy, np_wdata); end
    step();
    reset = 1'b0;
    clear_mon();
    step();
    n_checks++; if (np_write_en !== 1'b1 || np_wdata !== 32'h0100_0000) begin n_fail++; $display("FAIL rs_black: got %b/%h want 1/01000000", np_write_en, np_wdata); end
    repeat (20) step();
    n_checks++; if (en_cyc.size() !== 2) begin n_fail++; $display("FAIL rs_single: got %0d writes want 2", en_cyc.size()); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL rs_proto: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_blink();
    test_wait_write();
    test_ctrl_toggle();
    test_reset_in_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/np_pattern_seq.md
NP_PATTERN_SEQ -- requirements
Module: np_pattern_seq

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 8400, giving the idle wait after each send (covers 24 bit periods plus the latch hold).
REQ-002 SHALL have parameter TICK_CYCLES, default 100000, giving the pclk cycles per 1 ms pattern tick.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 pclk  input  1  clock (100 MHz).
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_sel  input  1  block select; a write occurs only when cfg_we & cfg_sel.
REQ-008 cfg_addr  input  8  register address.
REQ-009 cfg_wdata  input  32  register write data.
REQ-010 np_write_en  output  1  write strobe to the downstream pixel driver.
REQ-011 np_en  output  1  select to the downstream pixel driver; always equals np_write_en.
REQ-012 np_addr  output  8  constant 8'h00.
REQ-013 np_wdata  output  32  command word to the pixel driver.
REQ-014 busy  output  1  high from the LOAD cycle through the last WAIT cycle.
REQ-015 phase  output  1  current pattern phase (1 = colour A).

Function
REQ-016 Register map SHALL be: 0x00 COLOR_A[23:0]; 0x04 COLOR_B[23:0]; 0x08 CTRL[1:0] pattern; 0x0C HALF_PERIOD[15:0] in ms ticks; any other address is ignored; unused data bits are ignored.
REQ-017 Pattern SHALL select the target colour: 0 off = 24'h0; 1 solid = A; 2 blink = phase ? A : 0; 3 alternate = phase ? A : B.
REQ-018 Tick counter SHALL count 0..TICK_CYCLES-1; at wrap it SHALL increment a half-period counter, which at HALF_PERIOD (0 treated as 1) clears and toggles phase.
REQ-019 A CTRL write SHALL set phase=1 and clear both counters; if it coincides with a tick or toggle, the CTRL write wins.
REQ-020 Any register write SHALL set refresh_pending.
REQ-021 FSM states SHALL be IDLE, LOAD, SEND and WAIT.
REQ-022 IDLE->LOAD SHALL occur when refresh_pending=1 or target != last_sent.
REQ-023 LOAD SHALL last one cycle with np_write_en=1 and np_wdata={7'b0,1'b1,target}, latching target into last_sent and clearing refresh_pending.
REQ-024 SEND SHALL last one cycle with np_write_en=1 and np_wdata=32'h0200_0000 (bit 25 = start send).
REQ-025 WAIT SHALL last exactly GUARD_CYCLES cycles with np_write_en=0, then return to IDLE.
REQ-026 All outputs SHALL be registered; the decision is made in IDLE in cycle N, np_write_en is high in cycles N+1 and N+2, and WAIT spans cycles N+3 to N+2+GUARD_CYCLES.
REQ-027 np_wdata SHALL be 0 whenever np_write_en=0.
REQ-028 Config writes during LOAD/SEND/WAIT SHALL update registers immediately but affect only the next frame.
REQ-029 A phase toggle during a frame SHALL produce exactly one follow-up frame after WAIT.
REQ-030 At most one frame SHALL be in flight at a time, and no np_write_en SHALL occur in WAIT.

Reset
REQ-031 Reset SHALL clear: COLOR_A/B=0, CTRL=0, HALF_PERIOD=0, counters=0, last_sent=0, phase=1, state=IDLE, np_write_en=0, np_en=0, np_wdata=0, busy=0.
REQ-032 Reset SHALL set refresh_pending=1, so the first cycle after release decides LOAD and sends a black frame.
REQ-033 Reset asserted mid-frame SHALL abort the frame at the next edge with no further write pulses.

Verification
REQ-034 Release reset -> writes 0x0100_0000 then 0x0200_0000 on consecutive cycles, then busy stays high for 8400 cycles, then IDLE.
REQ-035 Write A=0x00FF00, then CTRL=1 -> exactly one frame with word 0x0100_FF00; after WAIT, no further writes while idle.
REQ-036 TICK_CYCLES=4, HALF_PERIOD=2, CTRL=2, A=0x0000FF -> frames alternate 0x0100_00FF / 0x0100_0000 every 8 cycles or once per guard interval, whichever is later; phase toggles every 8 cycles.
REQ-037 Write COLOR_B during WAIT with CTRL=3 -> no np_write_en until WAIT ends; the next frame carries the new B on the B phase.
REQ-038 CTRL write on the same cycle as a phase toggle -> phase=1 and counters zeroed.
REQ-039 Reset asserted in SEND -> np_write_en=0 next cycle, then a black frame after release.
